// File: rtl/true_dpram_be.sv
// Single-clock true dual-port RAM with byte-lane write enables, selectable
// same-port read-during-write, optional output stage and a post-reset clear sweep.
`timescale 1ns/1ps
module true_dpram_be #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    BYTE_WIDTH = 8,
  parameter bit                    RDW_NEW    = 1'b1,
  parameter bit                    OUT_REG    = 1'b0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int                   BE_WIDTH   = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  input  logic                  en_a,
  input  logic [BE_WIDTH-1:0]   w_a,
  input  logic [ADDR_WIDTH-1:0] a_a,
  input  logic [DATA_WIDTH-1:0] d_a,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic                  v_a,
  input  logic                  en_b,
  input  logic [BE_WIDTH-1:0]   w_b,
  input  logic [ADDR_WIDTH-1:0] a_b,
  input  logic [DATA_WIDTH-1:0] d_b,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  v_b,
  output logic                  coll
);

  localparam int              DEPTH    = 2 ** ADDR_WIDTH;
  localparam int              CNT_W    = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** (ADDR_WIDTH - 1)) - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sweep_we;
  logic [ADDR_WIDTH-1:0] sw_addr_a, sw_addr_b;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  acc_a, acc_b, wr_a, wr_b, coll_now;
  logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b, rd_a, rd_b;

  logic [DATA_WIDTH-1:0] q1_a_q, q1_a_d, q1_b_q, q1_b_d;
  logic                  v1_a_q, v1_a_d, v1_b_q, v1_b_d, coll1_q, coll1_d;

  // Sweep: two words per cycle, port A takes the even address, port B the odd.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_we = ~rst;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_RUN;
      end
      ST_RUN:  ;
      default: state_d = ST_INIT;
    endcase
  end

  assign sw_addr_a = ADDR_WIDTH'(cnt_q) << 1;
  assign sw_addr_b = sw_addr_a | ADDR_WIDTH'(1);
  assign init_busy = rst | (state_q != ST_RUN);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc_a    = en_a & ~init_busy;
  assign acc_b    = en_b & ~init_busy;
  assign wr_a     = acc_a & (|w_a);
  assign wr_b     = acc_b & (|w_b);
  assign coll_now = wr_a & wr_b & (a_a == a_b);

  // Merged words: on a collision both ports see the A-over-B resolved word.
  always_comb begin
    old_a = mem[a_a];
    old_b = mem[a_b];
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (w_a[i])
        new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = d_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      else if (coll_now && w_b[i])
        new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = d_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (coll_now && w_a[i])
        new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = d_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      else if (w_b[i])
        new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = d_b[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    rd_a = (RDW_NEW && (|w_a)) ? new_a : old_a;
    rd_b = (RDW_NEW && (|w_b)) ? new_b : old_b;
  end

  // NOTE: the array has no reset branch; the post-reset sweep clears it instead.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sw_addr_a] <= INIT_VALUE;
      mem[sw_addr_b] <= INIT_VALUE;
    end else begin
      for (int i = 0; i < BE_WIDTH; i++)
        if (wr_b && w_b[i]) mem[a_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= d_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      // Port A is applied last so it owns lanes both ports enable.
      for (int i = 0; i < BE_WIDTH; i++)
        if (wr_a && w_a[i]) mem[a_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= d_a[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_comb begin
    v1_a_d  = acc_a;
    v1_b_d  = acc_b;
    q1_a_d  = acc_a ? rd_a : q1_a_q;
    q1_b_d  = acc_b ? rd_b : q1_b_q;
    coll1_d = coll_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q1_a_q  <= '0;
      q1_b_q  <= '0;
      v1_a_q  <= 1'b0;
      v1_b_q  <= 1'b0;
      coll1_q <= 1'b0;
    end else begin
      q1_a_q  <= q1_a_d;
      q1_b_q  <= q1_b_d;
      v1_a_q  <= v1_a_d;
      v1_b_q  <= v1_b_d;
      coll1_q <= coll1_d;
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [DATA_WIDTH-1:0] q2_a_q, q2_b_q;
    logic                  v2_a_q, v2_b_q, coll2_q;

    // q1 only moves on an access, so a plain copy keeps q stable while v is low.
    always_ff @(posedge clk) begin
      if (rst) begin
        q2_a_q  <= '0;
        q2_b_q  <= '0;
        v2_a_q  <= 1'b0;
        v2_b_q  <= 1'b0;
        coll2_q <= 1'b0;
      end else begin
        q2_a_q  <= q1_a_q;
        q2_b_q  <= q1_b_q;
        v2_a_q  <= v1_a_q;
        v2_b_q  <= v1_b_q;
        coll2_q <= coll1_q;
      end
    end

    assign q_a  = q2_a_q;
    assign q_b  = q2_b_q;
    assign v_a  = v2_a_q;
    assign v_b  = v2_b_q;
    assign coll = coll2_q;
  end else begin : g_no_out_reg
    assign q_a  = q1_a_q;
    assign q_b  = q1_b_q;
    assign v_a  = v1_a_q;
    assign v_b  = v1_b_q;
    assign coll = coll1_q;
  end

endmodule

// File: tb/tb_true_dpram_be.sv
// Bench for true_dpram_be: two instances (new-data/no output stage and
// old-data/output stage) share stimulus; a cycle-stamped scoreboard checks q/v/coll.
`timescale 1ns/1ps
module tb_true_dpram_be;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] INIT_V = 32'hA5A5A5A5;

  typedef struct {
    int          cyc;
    int          dut;
    int          port;   // 0 = A, 1 = B, 2 = coll
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [3:0]  w_a = '0, w_b = '0;
  logic [3:0]  a_a = '0, a_b = '0;
  logic [31:0] d_a = '0, d_b = '0;

  logic        init_busy0, init_busy1;
  logic [31:0] q_a0, q_b0, q_a1, q_b1;
  logic        v_a0, v_b0, v_a1, v_b1, coll0, coll1;

  logic [31:0] obs_q [2][2];
  logic        obs_v [2][3];

  exp_t        sb [$];
  logic [31:0] mem_m [DEPTH];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  true_dpram_be #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8),
    .RDW_NEW(1'b1), .OUT_REG(1'b0), .INIT_VALUE(INIT_V)
  ) dut0 (
    .clk(clk), .rst(rst), .init_busy(init_busy0),
    .en_a(en_a), .w_a(w_a), .a_a(a_a), .d_a(d_a), .q_a(q_a0), .v_a(v_a0),
    .en_b(en_b), .w_b(w_b), .a_b(a_b), .d_b(d_b), .q_b(q_b0), .v_b(v_b0),
    .coll(coll0)
  );

  true_dpram_be #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8),
    .RDW_NEW(1'b0), .OUT_REG(1'b1), .INIT_VALUE(INIT_V)
  ) dut1 (
    .clk(clk), .rst(rst), .init_busy(init_busy1),
    .en_a(en_a), .w_a(w_a), .a_a(a_a), .d_a(d_a), .q_a(q_a1), .v_a(v_a1),
    .en_b(en_b), .w_b(w_b), .a_b(a_b), .d_b(d_b), .q_b(q_b1), .v_b(v_b1),
    .coll(coll1)
  );

  assign obs_q[0][0] = q_a0;
  assign obs_q[0][1] = q_b0;
  assign obs_q[1][0] = q_a1;
  assign obs_q[1][1] = q_b1;
  assign obs_v[0][0] = v_a0;
  assign obs_v[0][1] = v_b0;
  assign obs_v[0][2] = coll0;
  assign obs_v[1][0] = v_a1;
  assign obs_v[1][1] = v_b1;
  assign obs_v[1][2] = coll1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Every cycle: each strobe must be high exactly when an item is due, with its data.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 3; p++) begin
          int idx;
          idx = -1;
          foreach (sb[i])
            if (idx < 0 && sb[i].cyc == cyc && sb[i].dut == d && sb[i].port == p) idx = i;
          check($sformatf("dut%0d port%0d strobe @%0d", d, p, cyc),
                {31'b0, obs_v[d][p]}, {31'b0, idx >= 0});
          if (idx >= 0) begin
            if (p < 2)
              check($sformatf("dut%0d port%0d data @%0d", d, p, cyc), obs_q[d][p], sb[idx].data);
            sb.delete(idx);
          end
        end
      end
    end
  end

  task automatic idle();
    en_a = 1'b0; w_a = '0;
    en_b = 1'b0; w_b = '0;
  endtask

  // Drive one cycle of requests and queue what each instance should return.
  task automatic access(input logic ea, input logic [3:0] wa, input logic [3:0] aa, input logic [31:0] da,
                        input logic eb, input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db);
    logic [31:0] nm [DEPTH];
    en_a = ea; w_a = wa; a_a = aa; d_a = da;
    en_b = eb; w_b = wb; a_b = ab; d_b = db;
    nm = mem_m;
    if (eb) for (int i = 0; i < 4; i++) if (wb[i]) nm[ab][i*8 +: 8] = db[i*8 +: 8];
    if (ea) for (int i = 0; i < 4; i++) if (wa[i]) nm[aa][i*8 +: 8] = da[i*8 +: 8];
    for (int d = 0; d < 2; d++) begin
      bit new_data;
      new_data = (d == 0);
      if (ea) sb.push_back('{cyc + 1 + d, d, 0, (new_data && wa != 0) ? nm[aa] : mem_m[aa]});
      if (eb) sb.push_back('{cyc + 1 + d, d, 1, (new_data && wb != 0) ? nm[ab] : mem_m[ab]});
      if (ea && eb && wa != 0 && wb != 0 && aa == ab) sb.push_back('{cyc + 1 + d, d, 2, 32'h0});
    end
    mem_m = nm;
    @(posedge clk); #1;
  endtask

  task automatic junk();
    en_a = 1'b1; w_a = 4'hF; a_a = 4'd3;  d_a = 32'h0BAD0BAD;
    en_b = 1'b1; w_b = 4'hF; a_b = 4'd15; d_b = 32'h0BAD0BAD;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    junk();
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].cyc > cyc) sb.delete(i);
    @(posedge clk); #1;
    check("rst q_a0", q_a0, 32'h0);
    check("rst q_b0", q_b0, 32'h0);
    check("rst q_a1", q_a1, 32'h0);
    check("rst q_b1", q_b1, 32'h0);
    check("rst v/coll dut0", {29'b0, v_a0, v_b0, coll0}, 32'h0);
    check("rst v/coll dut1", {29'b0, v_a1, v_b1, coll1}, 32'h0);
    check("rst init_busy", {30'b0, init_busy0, init_busy1}, 32'h3);
    rst = 1'b0;
    foreach (mem_m[i]) mem_m[i] = INIT_V;
  endtask

  // Keeps hammering both ports while busy; returns the number of busy cycles.
  task automatic wait_sweep(output int n);
    n = 0;
    while (init_busy0 === 1'b1 && n < 40) begin
      junk();
      n++;
      @(posedge clk); #1;
    end
    idle();
    check("sweep init_busy1 low", {31'b0, init_busy1}, 32'h0);
  endtask

  initial begin
    int n;

    apply_reset();
    mon_en = 1'b1;
    wait_sweep(n);
    check("sweep length", n, 8);

    for (int i = 0; i < 16; i++)
      access(1'b1, 4'h0, 4'(i), '0, 1'b1, 4'h0, 4'(i + 8), '0);

    access(1'b1, 4'hF, 4'd3, 32'h11223344, 1'b0, 4'h0, 4'd0, '0);
    access(1'b1, 4'b0101, 4'd3, 32'hFFFFFFFF, 1'b0, 4'h0, 4'd0, '0);
    access(1'b1, 4'h0, 4'd3, '0, 1'b1, 4'h0, 4'd3, '0);

    access(1'b1, 4'hF, 4'd5, 32'hAAAAAAAA, 1'b1, 4'b0011, 4'd5, 32'hBBBBBBBB);
    access(1'b1, 4'h0, 4'd5, '0, 1'b1, 4'h0, 4'd5, '0);
    access(1'b1, 4'b0011, 4'd5, 32'hAAAAAAAA, 1'b1, 4'b1100, 4'd5, 32'hBBBBBBBB);
    access(1'b1, 4'h0, 4'd5, '0, 1'b1, 4'h0, 4'd5, '0);

    access(1'b1, 4'hF, 4'd7, 32'hDEADBEEF, 1'b1, 4'h0, 4'd7, '0);
    access(1'b0, 4'h0, 4'd0, '0, 1'b1, 4'h0, 4'd7, '0);

    access(1'b1, 4'h0, 4'd0, '0, 1'b1, 4'b1000, 4'd0, 32'h12345678);
    access(1'b1, 4'hF, 4'd15, 32'h0F0F0F0F, 1'b1, 4'b0110, 4'd14, 32'hC3C3C3C3);
    access(1'b1, 4'h0, 4'd15, '0, 1'b1, 4'h0, 4'd14, '0);
    access(1'b0, 4'hF, 4'd9, 32'h11111111, 1'b1, 4'hF, 4'd9, 32'h22222222);
    access(1'b1, 4'h0, 4'd9, '0, 1'b1, 4'h0, 4'd0, '0);

    access(1'b1, 4'h0, 4'd3, '0, 1'b1, 4'h0, 4'd5, '0);
    access(1'b1, 4'hF, 4'd7, 32'h77777777, 1'b1, 4'h0, 4'd15, '0);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      junk();
      @(posedge clk); #1;
    end
    check("mid-sweep busy", {30'b0, init_busy0, init_busy1}, 32'h3);
    apply_reset();
    wait_sweep(n);
    check("restarted sweep length", n, 8);

    access(1'b1, 4'h0, 4'd3, '0, 1'b1, 4'h0, 4'd5, '0);
    access(1'b1, 4'h0, 4'd7, '0, 1'b1, 4'h0, 4'd15, '0);
    access(1'b1, 4'h0, 4'd0, '0, 1'b1, 4'h0, 4'd14, '0);
    idle();
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
